// File: rtl/uart_rx_core.sv
// UART receiver core: 2-flop line sync, tick-driven bit FSM, valid/ready output hold with overrun flag.
// Define RX_MAJORITY_VOTE_EN for 2-of-3 sampling around mid-bit; otherwise the single mid-bit sample decides.
module uart_rx_core (
  input  logic       clk,
  input  logic       rst,
  input  logic       AcqSig_i,
  input  logic       Rx_i,
  input  logic [4:0] AcqPerBit_i,
  input  logic       ParityEn_i,
  input  logic       ParityOdd_i,
  input  logic       RxReady_i,
  output logic [7:0] RxData_o,
  output logic       RxValid_o,
  output logic       ParityErr_o,
  output logic       FrameErr_o,
  output logic       OverrunErr_o,
  output logic       Busy_o
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // FSM state bundled so it can be probed as one object.
  typedef struct packed {
    logic [2:0] state;
    logic [4:0] tick;
    logic [2:0] bit_idx;
  } fsm_t;

  fsm_t       fsm;
  logic       rx_meta;
  logic       rx_sync;
  logic [4:0] per_q;
  logic       par_en_q;
  logic       par_odd_q;
  logic       par_acc;
  logic [7:0] shreg;
  logic [4:0] tick_next;
  logic [4:0] mid;
  logic       active;
  logic       wrap;
  logic       decide;
  logic       bit_val;
  logic       complete;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= Rx_i;
      rx_sync <= rx_meta;
    end
  end

`ifdef RX_MAJORITY_VOTE_EN
  logic vote_a;
  logic vote_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vote_a <= 1'b1;
      vote_b <= 1'b1;
    end else if (AcqSig_i) begin
      if (tick_next == mid - 5'd1) vote_a <= rx_sync;
      if (tick_next == mid)        vote_b <= rx_sync;
    end
  end
`endif

  // tick holds the index of the last processed tick; tick_next is the index of the current one.
  always_comb begin
    mid       = {1'b0, per_q[4:1]};
    tick_next = (fsm.tick == per_q - 5'd1) ? 5'd0 : fsm.tick + 5'd1;
    active    = AcqSig_i && (fsm.state != ST_IDLE);
    wrap      = active && (tick_next == 5'd0);
`ifdef RX_MAJORITY_VOTE_EN
    decide    = active && (tick_next == mid + 5'd1);
    bit_val   = (vote_a & vote_b) | (vote_a & rx_sync) | (vote_b & rx_sync);
`else
    decide    = active && (tick_next == mid);
    bit_val   = rx_sync;
`endif
    complete  = decide && (fsm.state == ST_STOP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm       <= '0;
      per_q     <= 5'd0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      par_acc   <= 1'b0;
      shreg     <= 8'h00;
    end else if (AcqSig_i) begin
      if (fsm.state == ST_IDLE) begin
        if (!rx_sync) begin
          fsm.state   <= ST_START;
          fsm.tick    <= 5'd0;
          fsm.bit_idx <= 3'd0;
          per_q       <= AcqPerBit_i;
          par_en_q    <= ParityEn_i;
          par_odd_q   <= ParityOdd_i;
          par_acc     <= 1'b0;
        end
      end else begin
        fsm.tick <= tick_next;
        case (fsm.state)
          ST_START: begin
            if (decide && bit_val) begin
              fsm.state <= ST_IDLE;
              fsm.tick  <= 5'd0;
            end else if (wrap) begin
              fsm.state <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (decide) begin
              shreg   <= {bit_val, shreg[7:1]};
              par_acc <= par_acc ^ bit_val;
            end
            if (wrap) begin
              if (fsm.bit_idx == 3'd7) fsm.state <= par_en_q ? ST_PARITY : ST_STOP;
              else fsm.bit_idx <= fsm.bit_idx + 3'd1;
            end
          end
          ST_PARITY: begin
            if (decide) par_acc <= par_acc ^ bit_val;
            if (wrap) fsm.state <= ST_STOP;
          end
          ST_STOP: begin
            if (decide) begin
              fsm.state <= ST_IDLE;
              fsm.tick  <= 5'd0;
            end
          end
          default: begin
            fsm.state <= ST_IDLE;
            fsm.tick  <= 5'd0;
          end
        endcase
      end
    end
  end

  // Handshake: RxValid_o holds data/flags stable until an edge with RxValid_o and RxReady_i both high.
  // A byte completing while the held one is not being taken on that edge is dropped and flagged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RxData_o     <= 8'h00;
      RxValid_o    <= 1'b0;
      ParityErr_o  <= 1'b0;
      FrameErr_o   <= 1'b0;
      OverrunErr_o <= 1'b0;
    end else begin
      OverrunErr_o <= 1'b0;
      if (complete) begin
        if (RxValid_o && !RxReady_i) begin
          OverrunErr_o <= 1'b1;
        end else begin
          RxData_o    <= shreg;
          ParityErr_o <= par_en_q && (par_acc != par_odd_q);
          FrameErr_o  <= !bit_val;
          RxValid_o   <= 1'b1;
        end
      end else if (RxValid_o && RxReady_i) begin
        RxValid_o <= 1'b0;
      end
    end
  end

  assign Busy_o = (fsm.state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: frame driver, expected-queue scoreboard with a decoupled output monitor.
module tb_uart_rx_core;

`ifdef RX_MAJORITY_VOTE_EN
  localparam int VOTE_LAG = 1;
`else
  localparam int VOTE_LAG = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       AcqSig_i = 1'b0;
  logic       Rx_i = 1'b1;
  logic [4:0] AcqPerBit_i = 5'd16;
  logic       ParityEn_i = 1'b0;
  logic       ParityOdd_i = 1'b0;
  logic       RxReady_i = 1'b1;
  logic [7:0] RxData_o;
  logic       RxValid_o;
  logic       ParityErr_o;
  logic       FrameErr_o;
  logic       OverrunErr_o;
  logic       Busy_o;

  int  total = 0;
  int  bad = 0;
  int  tick_cnt = 0;
  logic last_acq = 1'b0;
  int  tick_gap = 22;
  bit  rand_ready = 1'b0;
  int  ov_cycles = 0;
  int  ov_rises = 0;
  bit  prev_valid = 1'b0;
  bit  prev_acc = 1'b0;
  bit  prev_ov = 1'b0;
  logic [41:0] exp_q[$];
  logic [41:0] exp_e;

  uart_rx_core dut (
    .clk(clk), .rst(rst), .AcqSig_i(AcqSig_i), .Rx_i(Rx_i),
    .AcqPerBit_i(AcqPerBit_i), .ParityEn_i(ParityEn_i), .ParityOdd_i(ParityOdd_i),
    .RxReady_i(RxReady_i), .RxData_o(RxData_o), .RxValid_o(RxValid_o),
    .ParityErr_o(ParityErr_o), .FrameErr_o(FrameErr_o),
    .OverrunErr_o(OverrunErr_o), .Busy_o(Busy_o)
  );

  // clock / tick generation
  always #5 clk = ~clk;

  initial begin
    int c;
    c = 0;
    forever begin
      @(negedge clk);
      c++;
      if (c >= tick_gap) begin
        AcqSig_i = 1'b1;
        c = 0;
      end else begin
        AcqSig_i = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    last_acq <= AcqSig_i;
    if (AcqSig_i) tick_cnt <= tick_cnt + 1;
  end

  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (rand_ready) RxReady_i = 1'($urandom_range(0, 1));
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int k);
    int s;
    s = tick_cnt;
    while (tick_cnt < s + k) @(negedge clk);
  endtask

  // Drives one frame bit by bit; each bit spans per ticks. abort_bit >= 0 resets mid data bit.
  task automatic send_frame(input logic [7:0] data, input int per, input bit pen, input bit podd,
                            input bit bad_par, input bit stop_val, input bit push, input int abort_bit);
    int n;
    logic pbit;
    AcqPerBit_i = 5'(per);
    ParityEn_i  = pen;
    ParityOdd_i = podd;
    Rx_i = 1'b0;
    wait_ticks(per);
    for (int i = 0; i < 8; i++) begin
      Rx_i = data[i];
      if (i == abort_bit) begin
        wait_ticks(per / 2);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data", 32'(RxData_o), 32'h0);
        check("rst_valid", 32'(RxValid_o), 32'h0);
        check("rst_parity_err", 32'(ParityErr_o), 32'h0);
        check("rst_frame_err", 32'(FrameErr_o), 32'h0);
        check("rst_overrun", 32'(OverrunErr_o), 32'h0);
        check("rst_busy", 32'(Busy_o), 32'h0);
        Rx_i = 1'b1;
        rst = 1'b1;
        wait_ticks(per + 4);
        return;
      end
      wait_ticks(per);
    end
    if (pen) begin
      pbit = (^data) ^ podd ^ bad_par;
      Rx_i = pbit;
      wait_ticks(per);
    end
    Rx_i = stop_val;
    n = tick_cnt;
    if (push) exp_q.push_back({32'(n + 1 + per / 2 + VOTE_LAG), !stop_val, pen & bad_par, data});
    wait_ticks(per);
    Rx_i = 1'b1;
    wait_ticks(per + 4);
    check("busy_after_frame", 32'(Busy_o), 32'h0);
  endtask

  // scoreboard monitor: a new byte is presented when valid rises or follows an acceptance
  always @(negedge clk) begin
    if (RxValid_o && (!prev_valid || prev_acc)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid data=%0h required=none", RxData_o);
      end else begin
        exp_e = exp_q.pop_front();
        check("rx_data", 32'(RxData_o), 32'(exp_e[7:0]));
        check("parity_err", 32'(ParityErr_o), 32'(exp_e[8]));
        check("frame_err", 32'(FrameErr_o), 32'(exp_e[9]));
        if (!prev_valid) begin
          check("valid_on_tick_edge", 32'(last_acq), 32'h1);
          check("valid_latency", 32'(tick_cnt), exp_e[41:10]);
        end
      end
    end
    if (OverrunErr_o) ov_cycles++;
    if (OverrunErr_o && !prev_ov) ov_rises++;
    prev_valid = RxValid_o;
    prev_acc   = RxValid_o && RxReady_i;
    prev_ov    = OverrunErr_o;
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("reset_data", 32'(RxData_o), 32'h0);
    check("reset_valid", 32'(RxValid_o), 32'h0);
    check("reset_parity_err", 32'(ParityErr_o), 32'h0);
    check("reset_frame_err", 32'(FrameErr_o), 32'h0);
    check("reset_overrun", 32'(OverrunErr_o), 32'h0);
    check("reset_busy", 32'(Busy_o), 32'h0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    send_frame(8'hA5, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    send_frame(8'h03, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, -1);
    send_frame(8'h03, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    send_frame(8'h55, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    send_frame(8'h5A, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);

    // short low pulse on the line must be rejected as a glitch
    AcqPerBit_i = 5'd16;
    Rx_i = 1'b0;
    n = tick_cnt;
    wait_ticks(2);
    check("glitch_busy_high", 32'(Busy_o), 32'h1);
    wait_ticks(1);
    Rx_i = 1'b1;
    wait_ticks(7);
    check("glitch_ticks_elapsed", 32'(tick_cnt - n), 32'd10);
    check("glitch_busy_low", 32'(Busy_o), 32'h0);
    wait_ticks(4);

    // consumer stalled: second byte is dropped, first is held
    RxReady_i = 1'b0;
    send_frame(8'h11, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    send_frame(8'h22, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    check("overrun_held_data", 32'(RxData_o), 32'h11);
    check("overrun_held_valid", 32'(RxValid_o), 32'h1);
    check("overrun_cycles", 32'(ov_cycles), 32'd1);
    check("overrun_pulses", 32'(ov_rises), 32'd1);
    RxReady_i = 1'b1;
    repeat (4) @(negedge clk);
    check("accept_clears_valid", 32'(RxValid_o), 32'h0);

    send_frame(8'hC3, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4);
    send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);

    tick_gap = 8;
    rand_ready = 1'b1;
    for (int f = 0; f < 8; f++) begin
      send_frame(8'($urandom_range(0, 255)), int'($urandom_range(4, 16)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0), 1'b1, -1);
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #3;
    RxReady_i = 1'b1;
    repeat (50) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("overrun_total", 32'(ov_cycles), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
